// File: rtl/uart_receiver.sv
// uart_receiver: oversampling 8N1 UART receiver with mid-bit sampling.
// Optional even-parity checking (8E1) is enabled by defining UART_RX_PARITY_EN.
// Every state change is gated by the baud x OVERSAMPLE tick enable. The raw
// rxd line is synchronised before any use.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       rx_perr
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    // Synchroniser flops. Both reset to the idle-high line level.
    logic sync1_q;
    logic rxd_s_q;

    state_t        state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [2:0]    bidx_q,   bidx_d;
    logic [7:0]    shift_q,  shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ferr_q, rx_ferr_d;
`ifdef UART_RX_PARITY_EN
    logic          parity_q, parity_d;
    logic          rx_perr_q, rx_perr_d;
`endif

    // Two-flop synchroniser for the asynchronous serial line. It runs every clk, not only on ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rxd_s_q <= sync1_q;
        end
    end

    // Next-state logic. With no tick everything holds, and rx_valid only pulses on the stop sample.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bidx_d     = bidx_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_d   = parity_q;
        rx_perr_d  = rx_perr_q;
`endif
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        if (!rxd_s_q) begin
                            state_d = S_DATA;
                            bidx_d  = 3'd0;
                        end else begin
                            // The line went high again before mid start bit, so treat it as a glitch.
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        shift_d = {rxd_s_q, shift_q[7:1]};
                        cnt_d   = '0;
                        bidx_d  = bidx_q + 3'd1;
                        if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_FULL) begin
                        parity_d = rxd_s_q;
                        cnt_d    = '0;
                        state_d  = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        rx_data_d  = shift_q;
                        rx_ferr_d  = ~rxd_s_q;
                        rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        rx_perr_d  = (^shift_q) ^ parity_q;
`endif
                        cnt_d      = '0;
                        // Going idle at mid stop bit lets a back-to-back start bit be caught on time.
                        state_d    = rxd_s_q ? S_IDLE : S_BREAK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rxd_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state, counters and registered outputs. All of them clear immediately on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bidx_q     <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bidx_q     <= bidx_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_RX_PARITY_EN
            parity_q   <= parity_d;
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_ferr  = rx_ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_perr  = rx_perr_q;
`else
    assign rx_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver (OVERSAMPLE=16, tick every 4 clk).
// Stimulus tasks push the expected frame result into a queue. A negedge monitor
// pops that queue on every rx_valid pulse and compares the outputs.
module tb_uart_receiver;

    localparam int OS       = 16;
    localparam int BIT_CLKS = OS * 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_perr;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic prev_valid  = 1'b0;
    logic [1:0] tick_div = 2'd0;

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .rx_perr  (rx_perr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick_div <= tick_div + 2'd1;
    assign tick = (tick_div == 2'd3);

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // Reference: the expected result of a frame follows directly from the framing rules.
    function automatic exp_t model(input logic [7:0] d, input logic stop, input logic pb);
        exp_t e;
        e.data = d;
        e.ferr = ~stop;
        e.perr = PAR ? ((^d) ^ pb) : 1'b0;
        return e;
    endfunction

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pb, input int gap_bits);
        exp_q.push_back(model(d, stop, pb));
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR) send_bit(pb);
        send_bit(stop);
        for (int i = 0; i < gap_bits; i++) send_bit(1'b1);
    endtask

    // Monitor: pops and compares one expected frame per rx_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid) begin
            check("valid_width", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: got frame %02h, required no frame", rx_data);
            end else begin
                e = exp_q.pop_front();
                $display("rx frame data=%02h ferr=%0b perr=%0b (expected %02h %0b %0b)",
                         rx_data, rx_ferr, rx_perr, e.data, e.ferr, e.perr);
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("rx_ferr", 32'(rx_ferr), 32'(e.ferr));
                check("rx_perr", 32'(rx_perr), 32'(e.perr));
            end
        end
        prev_valid = rx_valid;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       stop;
        logic       pb;
        int         gap;

        rxd = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data",  32'(rx_data),  32'd0);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_ferr",  32'(rx_ferr),  32'd0);
        check("reset_perr",  32'(rx_perr),  32'd0);
        rst = 1'b1;
        repeat (10) @(posedge clk);

        // Basic frame.
        send_frame(8'h55, 1'b1, ^8'h55, 2);
        check("drain_55", 32'(exp_q.size()), 32'd0);

        // Short low glitch followed by idle: no frame, data held.
        rxd = 1'b0;
        repeat (4 * 4) @(posedge clk);
        rxd = 1'b1;
        repeat (40 * 4) @(posedge clk);
        check("glitch_data_held", 32'(rx_data), 32'h55);
        check("glitch_no_frame",  32'(exp_q.size()), 32'd0);

        // Framing error with a held-low line, then recovery.
        send_frame(8'hA3, 1'b0, ^8'hA3, 0);
        send_bit(1'b0);
        send_bit(1'b0);
        check("break_data", 32'(rx_data), 32'hA3);
        check("break_ferr", 32'(rx_ferr), 32'd1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_frame(8'h0F, 1'b1, ^8'h0F, 2);
        check("drain_0f", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, ^8'h00, 0);
        send_frame(8'hFF, 1'b1, ^8'hFF, 0);
        send_frame(8'h81, 1'b1, ^8'h81, 2);
        check("drain_b2b", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 4 of 0x3C: the frame is abandoned.
        d = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rxd = d[4];
        repeat (BIT_CLKS / 2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_data",  32'(rx_data),  32'd0);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_ferr",  32'(rx_ferr),  32'd0);
        check("midrst_perr",  32'(rx_perr),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        send_frame(8'hC3, 1'b1, ^8'hC3, 2);
        check("drain_c3", 32'(exp_q.size()), 32'd0);

        // Parity cases (good parity bit, then bad parity bit).
        if (PAR) begin
            send_frame(8'h07, 1'b1, 1'b1, 2);
            send_frame(8'h07, 1'b1, 1'b0, 2);
            check("drain_par", 32'(exp_q.size()), 32'd0);
        end

        // Randomised frames: random data, stop and parity bits, and gaps.
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            pb   = 1'($urandom);
            gap  = stop ? int'($urandom_range(0, 2)) : 1 + int'($urandom_range(0, 1));
            send_frame(d, stop, pb, gap);
        end

        repeat (100) @(posedge clk);
        check("drain_final", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 OVERSAMPLE, 16, ticks per bit; SHALL be a power of two in the range 8..64.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  baud x OVERSAMPLE enable, one clk cycle wide, synchronous to clk; state SHALL advance only on clk edges where tick=1.
REQ-005 rxd  input  1  serial line, asynchronous to clk, idle high, 8N1 framing (8E1 with macro), LSB first.
REQ-006 rx_data  output  8  last received byte, held until the next completed frame.
REQ-007 rx_valid  output  1  single-clk pulse when rx_data, rx_ferr and rx_perr update.
REQ-008 rx_ferr  output  1  framing error of the last frame (stop bit sampled 0).
REQ-009 rx_perr  output  1  parity error of the last frame; constant 0 without the macro.

Function
REQ-010 rxd SHALL pass through a 2-flop synchronizer (rxd_s) before any use; both flops SHALL reset to 1.
REQ-011 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP and BREAK; tick count cnt and bit index bidx SHALL be internal counters.
REQ-012 IDLE: on a tick with rxd_s=0 -> START, cnt=0.
REQ-013 START: each tick cnt+1; at cnt=OVERSAMPLE/2-1, rxd_s=0 -> DATA with cnt=0, bidx=0; rxd_s=1 -> IDLE (glitch reject, no output change, no rx_valid).
REQ-014 DATA: each tick cnt+1; at cnt=OVERSAMPLE-1, rxd_s SHALL shift into the MSB of the shift register (right shift), cnt=0, bidx+1; after bidx 7 -> PARITY (macro) or STOP.
REQ-015 Sampling therefore SHALL occur at mid-bit, OVERSAMPLE ticks after the previous sample.
REQ-016 STOP: at cnt=OVERSAMPLE-1, rx_data <= shift register, rx_ferr <= ~rxd_s, rx_perr <= computed parity error; rx_valid=1 for exactly the next clk cycle.
REQ-017 STOP next state: rxd_s=1 -> IDLE; rxd_s=0 -> BREAK.
REQ-018 BREAK: SHALL remain until a tick with rxd_s=1, then -> IDLE; no new frame SHALL start while in BREAK.
REQ-019 A frame SHALL still be delivered when rx_ferr=1 (data not discarded).
REQ-020 Latency: rx_valid SHALL rise on the clk edge after the stop-sample tick edge, i.e. OVERSAMPLE/2 + 9*OVERSAMPLE ticks after start detection (+OVERSAMPLE with parity), plus 1 clk.
REQ-021 Back-to-back frames: a start bit beginning immediately after the stop bit SHALL be received without loss (IDLE is re-entered half a bit before the stop bit ends).
REQ-022 tick=0 cycles SHALL hold all state; rxd changes without a tick SHALL have no effect except in the synchronizer.
REQ-023 No new frame SHALL alter rx_data or the error flags before its own STOP sample.

Reset
REQ-024 With rst=0: state=IDLE, cnt=0, bidx=0, shift register=0, rx_data=8'h00, rx_valid=0, rx_ferr=0, rx_perr=0, synchronizer=1, all immediately and asynchronously.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no rx_valid; after release the receiver SHALL wait in IDLE for a new falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: the PARITY state SHALL exist; it samples at cnt=OVERSAMPLE-1 and then goes to STOP; rx_perr = (XOR of data bits) XOR parity bit, i.e. even parity expected.
REQ-027 Macro undefined: no PARITY state or logic; DATA goes directly to STOP; rx_perr tied to 0.

Verification (OVERSAMPLE=16, tick every 4 clk)
REQ-028 Frame 0x55, stop=1 -> one rx_valid pulse, rx_data=8'h55, rx_ferr=0, rx_perr=0; rx_valid exactly 1 clk wide.
REQ-029 rxd low for 4 ticks then high, idle for 40 ticks -> no rx_valid, state back to IDLE, rx_data unchanged.
REQ-030 Frame 0xA3 with stop=0, line held low 3 bit times, then high -> rx_data=8'hA3, rx_ferr=1; no second frame until the line returns high; next frame 0x0F -> rx_data=8'h0F, rx_ferr=0.
REQ-031 Frames 0x00, 0xFF, 0x81 back-to-back with no idle gap -> three rx_valid pulses carrying 8'h00, 8'hFF, 8'h81 in order.
REQ-032 rst pulsed low during data bit 4 of frame 0x3C -> all outputs 0 immediately, no rx_valid for that frame; following frame 0xC3 -> rx_data=8'hC3.
REQ-033 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> rx_perr=0; 0x07 with parity bit 0 -> rx_perr=1, rx_data=8'h07.
